fetch_unit: RTL

//  Instruction-fetch stage; the consumer end of the hazard unit's IF stall/flush outputs.
//  - Owns the PC and issues in-order req/gnt requests to instruction memory.
//  - Buffers returned words and presents {valid, pc, instr} to the IF/ID register.
//  - Holds its output while stalled.
//  - On a flush (taken branch), redirects to the branch target and discards wrong-path words, including in-flight ones.

---
 rtl/fetch_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Owns the PC, issues in-order req/gnt fetches, buffers returned words in a
// small response FIFO and presents {valid, pc, instr} to the IF/ID register.
// A flush redirects the PC and squashes every word still in flight.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect -> HALT).
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        iStall,
  input  logic        iFlush,
  input  logic [31:0] iBrTarget,
  output logic        oImemReq,
  output logic [31:0] oImemAddr,
  input  logic        iImemGnt,
  input  logic        iImemRvalid,
  input  logic [31:0] iImemRdata,
  output logic        oValid,
  output logic [31:0] oPC,
  output logic [31:0] oInstr,
  output logic        oMisalign
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   kill_q, kill_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [PW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     hold_pc_q, hold_pc_d;
  logic [31:0]     hold_instr_q, hold_instr_d;

  // Data storage: tag queue holds the address of each in-flight request,
  // FIFO holds returned {pc, word} pairs. Neither needs a reset.
  logic [31:0]     tag_mem    [BUF_DEPTH];
  logic [31:0]     fifo_pc    [BUF_DEPTH];
  logic [31:0]     fifo_instr [BUF_DEPTH];

  logic [CW:0]     credit_sum;
  logic            fifo_nonempty;
  logic            grant;
  logic            push;
  logic            pop;
  logic            kill_active;

  // Request credit, handshakes and FIFO-head presentation.
  always_comb begin
    credit_sum    = {1'b0, inflight_q} + {1'b0, count_q};
    fifo_nonempty = (count_q != '0);
    kill_active   = (kill_q != '0);
    oImemReq      = nRst & (state_q == RUN) & ~iFlush &
                    (credit_sum < (CW+1)'(BUF_DEPTH));
    oImemAddr     = pc_q;
    grant         = oImemReq & iImemGnt;
    // Killed (wrong-path) responses never reach the FIFO; a flush also
    // discards a live response arriving in the same cycle.
    push          = iImemRvalid & ~kill_active & ~iFlush;
    oValid        = fifo_nonempty & (state_q == RUN);
    pop           = oValid & ~iStall & ~iFlush;
    oPC           = fifo_nonempty ? fifo_pc[rd_q]    : hold_pc_q;
    oInstr        = fifo_nonempty ? fifo_instr[rd_q] : hold_instr_q;
    oMisalign     = misalign_q;
  end

  // Next-state for PC, credit counters, pointers, FSM and output hold regs.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inflight_d   = inflight_q + CW'(grant) - CW'(iImemRvalid);
    kill_d       = kill_q;
    count_d      = count_q + CW'(push) - CW'(pop);
    wr_d         = push ? wr_q + PW'(1) : wr_q;
    rd_d         = pop  ? rd_q + PW'(1) : rd_q;
    tag_wr_d     = grant       ? tag_wr_q + PW'(1) : tag_wr_q;
    tag_rd_d     = iImemRvalid ? tag_rd_q + PW'(1) : tag_rd_q;
    misalign_d   = misalign_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;

    // Remember the last presented entry so an empty FIFO keeps outputs steady.
    if (fifo_nonempty) begin
      hold_pc_d    = fifo_pc[rd_q];
      hold_instr_d = fifo_instr[rd_q];
    end

    if (iImemRvalid && kill_active) begin
      kill_d = kill_q - CW'(1);
    end

    if (grant) begin
      pc_d = pc_q + 32'd4;
    end

    if (iFlush) begin
      // Every request still outstanding after this cycle is wrong-path.
      // Grant is impossible here because req is masked by the flush.
      kill_d  = inflight_q - CW'(iImemRvalid);
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
      pc_d    = {iBrTarget[31:2], 2'b00};
`ifdef FETCH_ALIGN_CHECK_EN
      if (iBrTarget[1:0] != 2'b00) begin
        state_d    = HALT;
        misalign_d = 1'b1;
      end else begin
        state_d    = RUN;
        misalign_d = 1'b0;
      end
`else
      state_d    = RUN;
      misalign_d = 1'b0;
`endif
    end
  end

`ifndef FETCH_ALIGN_CHECK_EN
  // Target low bits are simply dropped when the alignment trap is disabled.
  logic unused_tgt_lo;
  assign unused_tgt_lo = ^iBrTarget[1:0];
`endif

  // Control and output-hold registers.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      inflight_q   <= '0;
      kill_q       <= '0;
      count_q      <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
      misalign_q   <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      kill_q       <= kill_d;
      count_q      <= count_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      tag_wr_q     <= tag_wr_d;
      tag_rd_q     <= tag_rd_d;
      misalign_q   <= misalign_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // Tag queue and response FIFO storage writes.
  always_ff @(posedge iClk) begin
    if (grant) begin
      tag_mem[tag_wr_q] <= pc_q;
    end
    if (push) begin
      fifo_pc[wr_q]    <= tag_mem[tag_rd_q];
      fifo_instr[wr_q] <= iImemRdata;
    end
  end

endmodule
